// File: rtl/bbc_clock_enable_gen_if.sv
// Register port of bbc_clock_enable_gen.
// Master drives strobe/address/data; slave returns combinational read data.
interface bbc_clock_enable_gen_if;
   logic        cfg_wr;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;

   modport master (
      output cfg_wr,
      output cfg_addr,
      output cfg_wdata,
      input  cfg_rdata
   );

   modport slave (
      input  cfg_wr,
      input  cfg_addr,
      input  cfg_wdata,
      output cfg_rdata
   );
endinterface

// File: rtl/bbc_clock_enable_gen.sv
// BBC-style clock-enable generator: base, CPU phi1/phi2 and slow-bus enables.
// Optional CLOCKGEN_STRETCH_COUNT_EN adds a stretch-cycle counter at addr 7.
module bbc_clock_enable_gen #(
   parameter int NUM_SLOW     = 2,
   parameter int DIV_W        = 8,
   parameter int DEF_BASE_M1  = 11,
   parameter int DEF_CPU_M1   = 2,
   parameter int DEF_RATIO_M1 = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   bbc_clock_enable_gen_if.slave cfg,
   input  logic [NUM_SLOW-1:0]   slow_access_req,
   output logic                  enable_cpu,
   output logic [1:0]            phi,
   output logic                  base_rise_enable,
   output logic                  base_high,
   output logic [NUM_SLOW-1:0]   slow_rise,
   output logic [NUM_SLOW-1:0]   slow_fall,
   output logic                  reset_cpu,
   output logic                  stretching
);
   typedef enum logic {PHI1, PHI2} phase_e;

   localparam logic [DIV_W-1:0] BASE_RST  = DIV_W'(DEF_BASE_M1);
   localparam logic [DIV_W-1:0] CPU_RST   = DIV_W'(DEF_CPU_M1);
   localparam logic [DIV_W-1:0] RATIO_RST = DIV_W'(DEF_RATIO_M1);
   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

   phase_e              phase_q, phase_d;
   logic [DIV_W-1:0]    bc_q, bc_d;
   logic [DIV_W-1:0]    cc_q, cc_d;
   logic [DIV_W-1:0]    base_m1_q, base_m1_d;
   logic [DIV_W-1:0]    cpu_m1_q, cpu_m1_d;
   logic [DIV_W-1:0]    sk_q [NUM_SLOW];
   logic [DIV_W-1:0]    sk_d [NUM_SLOW];
   logic [DIV_W-1:0]    ratio_m1_q [NUM_SLOW];
   logic [DIV_W-1:0]    ratio_m1_d [NUM_SLOW];
   logic [NUM_SLOW-1:0] level_q, level_d;
   logic [NUM_SLOW-1:0] sel_q, sel_d;
   logic                reset_cpu_q, reset_cpu_d;
   logic                cpu_disable_q, cpu_disable_d;
   logic                stretching_q, stretching_d;
   logic                base_high_q, base_high_d;

   logic                base_tick;
   logic                raw_tick;
   logic                cpu_tick;
   logic [NUM_SLOW-1:0] slow_tgl;
   logic [NUM_SLOW-1:0] req_oh;
   logic                slow_hold;
   logic                sel_fall;
   logic                unused_wdata;

`ifdef CLOCKGEN_STRETCH_COUNT_EN
   logic [15:0]         stretch_cnt_q, stretch_cnt_d;
`endif

   assign unused_wdata = ^cfg.cfg_wdata;

   // cc also clears on its own tick so the CPU rate repeats between base ticks
   always_comb begin
      base_tick   = (bc_q >= base_m1_q);
      raw_tick    = base_tick | (cc_q >= cpu_m1_q);
      cpu_tick    = raw_tick & ~cpu_disable_q;
      bc_d        = base_tick ? '0 : bc_q + ONE;
      cc_d        = raw_tick ? '0 : cc_q + ONE;
      base_high_d = base_tick;
      for (int k = 0; k < NUM_SLOW; k++) begin
         slow_tgl[k] = base_tick & (sk_q[k] >= ratio_m1_q[k]);
         sk_d[k]     = sk_q[k];
         if (base_tick) begin
            sk_d[k] = slow_tgl[k] ? '0 : sk_q[k] + ONE;
         end
      end
      level_d   = level_q ^ slow_tgl;
      slow_rise = slow_tgl & ~level_q;
      slow_fall = slow_tgl & level_q;
   end

   always_comb begin
      req_oh       = slow_access_req & (~slow_access_req + NUM_SLOW'(1));
      slow_hold    = |(req_oh & level_q);
      sel_fall     = |(sel_q & slow_fall);
      phase_d      = phase_q;
      stretching_d = stretching_q;
      sel_d        = sel_q;
      enable_cpu   = 1'b0;
      if (!cpu_disable_q) begin
         unique case (phase_q)
            PHI1: begin
               if (cpu_tick && !slow_hold) begin
                  phase_d      = PHI2;
                  stretching_d = |req_oh;
                  sel_d        = req_oh;
               end
            end
            PHI2: begin
               if (stretching_q ? sel_fall : cpu_tick) begin
                  phase_d      = PHI1;
                  stretching_d = 1'b0;
                  enable_cpu   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      base_m1_d     = base_m1_q;
      cpu_m1_d      = cpu_m1_q;
      reset_cpu_d   = reset_cpu_q;
      cpu_disable_d = cpu_disable_q;
      for (int k = 0; k < NUM_SLOW; k++) begin
         ratio_m1_d[k] = ratio_m1_q[k];
      end
      if (cfg.cfg_wr) begin
         unique case (1'b1)
            cfg.cfg_addr == 3'd0: begin
               base_m1_d = cfg.cfg_wdata[DIV_W-1:0];
               cpu_m1_d  = cfg.cfg_wdata[16 +: DIV_W];
            end
            cfg.cfg_addr == 3'd1: begin
               reset_cpu_d   = cfg.cfg_wdata[0];
               cpu_disable_d = cfg.cfg_wdata[1];
            end
            default: ;
         endcase
         for (int k = 0; k < NUM_SLOW; k++) begin
            if (cfg.cfg_addr == 3'(k + 2)) begin
               ratio_m1_d[k] = cfg.cfg_wdata[DIV_W-1:0];
            end
         end
      end
   end

   always_comb begin
      cfg.cfg_rdata = '0;
      unique case (1'b1)
         cfg.cfg_addr == 3'd0: begin
            cfg.cfg_rdata[DIV_W-1:0]   = base_m1_q;
            cfg.cfg_rdata[16 +: DIV_W] = cpu_m1_q;
         end
         cfg.cfg_addr == 3'd1: begin
            cfg.cfg_rdata[1:0] = {cpu_disable_q, reset_cpu_q};
         end
         default: ;
      endcase
      for (int k = 0; k < NUM_SLOW; k++) begin
         if (cfg.cfg_addr == 3'(k + 2)) begin
            cfg.cfg_rdata[DIV_W-1:0] = ratio_m1_q[k];
         end
      end
`ifdef CLOCKGEN_STRETCH_COUNT_EN
      if (cfg.cfg_addr == 3'd7) begin
         cfg.cfg_rdata = {16'd0, stretch_cnt_q};
      end
`endif
   end

`ifdef CLOCKGEN_STRETCH_COUNT_EN
   always_comb begin
      stretch_cnt_d = stretch_cnt_q;
      if (cfg.cfg_wr && cfg.cfg_addr == 3'd7) begin
         stretch_cnt_d = '0;
      end else if (stretching_q && stretch_cnt_q != 16'hFFFF) begin
         stretch_cnt_d = stretch_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stretch_cnt_q <= '0;
      end else begin
         stretch_cnt_q <= stretch_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q       <= PHI1;
         bc_q          <= '0;
         cc_q          <= '0;
         base_m1_q     <= BASE_RST;
         cpu_m1_q      <= CPU_RST;
         level_q       <= '0;
         sel_q         <= '0;
         reset_cpu_q   <= 1'b0;
         cpu_disable_q <= 1'b0;
         stretching_q  <= 1'b0;
         base_high_q   <= 1'b0;
         for (int k = 0; k < NUM_SLOW; k++) begin
            sk_q[k]       <= '0;
            ratio_m1_q[k] <= RATIO_RST;
         end
      end else begin
         phase_q       <= phase_d;
         bc_q          <= bc_d;
         cc_q          <= cc_d;
         base_m1_q     <= base_m1_d;
         cpu_m1_q      <= cpu_m1_d;
         level_q       <= level_d;
         sel_q         <= sel_d;
         reset_cpu_q   <= reset_cpu_d;
         cpu_disable_q <= cpu_disable_d;
         stretching_q  <= stretching_d;
         base_high_q   <= base_high_d;
         for (int k = 0; k < NUM_SLOW; k++) begin
            sk_q[k]       <= sk_d[k];
            ratio_m1_q[k] <= ratio_m1_d[k];
         end
      end
   end

   assign phi              = (phase_q == PHI2) ? 2'b10 : 2'b01;
   assign base_rise_enable = base_tick;
   assign base_high        = base_high_q;
   assign reset_cpu        = reset_cpu_q;
   assign stretching       = stretching_q;
endmodule

// File: tb/tb_bbc_clock_enable_gen.sv
// Directed bench for bbc_clock_enable_gen: vector tables plus
// hand-written multi-cycle sequences (stretch, hold, disable, reset).
module tb_bbc_clock_enable_gen;
   localparam int NS = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NS-1:0] slow_access_req = '0;
   logic          enable_cpu;
   logic [1:0]    phi;
   logic          base_rise_enable;
   logic          base_high;
   logic [NS-1:0] slow_rise;
   logic [NS-1:0] slow_fall;
   logic          reset_cpu;
   logic          stretching;

   bbc_clock_enable_gen_if cfg_if ();

   bbc_clock_enable_gen #(
      .NUM_SLOW     (NS),
      .DIV_W        (8),
      .DEF_BASE_M1  (11),
      .DEF_CPU_M1   (2),
      .DEF_RATIO_M1 (0)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cfg              (cfg_if.slave),
      .slow_access_req  (slow_access_req),
      .enable_cpu       (enable_cpu),
      .phi              (phi),
      .base_rise_enable (base_rise_enable),
      .base_high        (base_high),
      .slow_rise        (slow_rise),
      .slow_fall        (slow_fall),
      .reset_cpu        (reset_cpu),
      .stretching       (stretching)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       br;
      logic       bh;
      logic       en;
      logic [1:0] ph;
      logic [1:0] sr;
      logic [1:0] sf;
      logic       st;
   } obs_t;

   typedef struct {
      bit            rst;
      int            cyc;
      logic [NS-1:0] req;
      obs_t          exp;
   } vec_t;

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        rcpu;
   } reg_t;

   vec_t  tv[$];
   reg_t  rv[$];
   int    vecs = 0;
   int    errs = 0;
   int    cyc = 0;
   int    bad;
   int    rises;
   logic [11:0] bits;

   function automatic void mk(bit rst, int c, logic [1:0] req,
                              logic br, logic bh, logic en,
                              logic [1:0] ph, logic [1:0] sr,
                              logic [1:0] sf, logic st);
      vec_t v;
      v.rst = rst;
      v.cyc = c;
      v.req = req;
      v.exp = '{br: br, bh: bh, en: en, ph: ph,
                sr: sr, sf: sf, st: st};
      tv.push_back(v);
   endfunction

   function automatic void mr(bit wr, logic [2:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic rc);
      reg_t r;
      r.wr    = wr;
      r.addr  = a;
      r.wdata = wd;
      r.rdata = rd;
      r.rcpu  = rc;
      rv.push_back(r);
   endfunction

   function automatic obs_t sample();
      return '{br: base_rise_enable, bh: base_high, en: enable_cpu,
               ph: phi, sr: slow_rise, sf: slow_fall, st: stretching};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      cfg_if.cfg_wr    = 1'b0;
      slow_access_req  = '0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic cfg_wr(logic [2:0] a, logic [31:0] d);
      cfg_if.cfg_wr    = 1'b1;
      cfg_if.cfg_addr  = a;
      cfg_if.cfg_wdata = d;
      tick();
      cfg_if.cfg_wr    = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_if.cfg_wr    = 1'b0;
      cfg_if.cfg_addr  = '0;
      cfg_if.cfg_wdata = '0;

      // defaults, no requests
      mk(1,  0, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0,  2, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0,  3, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
      mk(0,  5, 2'b00, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      mk(0,  6, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0, 11, 2'b00, 1, 0, 1, 2'b10, 2'b11, 2'b00, 0);
      mk(0, 12, 2'b00, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0, 17, 2'b00, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      mk(0, 23, 2'b00, 1, 0, 1, 2'b10, 2'b00, 2'b11, 0);
      mk(0, 24, 2'b00, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0, 35, 2'b00, 1, 0, 1, 2'b10, 2'b11, 2'b00, 0);
      mk(0, 47, 2'b00, 1, 0, 1, 2'b10, 2'b00, 2'b11, 0);
      // request channel 0 while its level is low: stretch to slow_fall
      mk(1,  0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0,  2, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      mk(0,  3, 2'b01, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1);
      mk(0,  5, 2'b01, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1);
      mk(0, 11, 2'b01, 1, 0, 0, 2'b10, 2'b11, 2'b00, 1);
      mk(0, 22, 2'b01, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1);
      mk(0, 23, 2'b01, 1, 0, 1, 2'b10, 2'b00, 2'b11, 1);
      mk(0, 24, 2'b00, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0);

      // register port: read sees old value, write lands next cycle
      mr(0, 3'd0, 32'h0,         32'h0002_000B, 0);
      mr(0, 3'd1, 32'h0,         32'h0,         0);
      mr(0, 3'd2, 32'h0,         32'h0,         0);
      mr(0, 3'd3, 32'h0,         32'h0,         0);
      mr(0, 3'd5, 32'h0,         32'h0,         0);
      mr(0, 3'd7, 32'h0,         32'h0,         0);
      mr(1, 3'd2, 32'hFFFF_FF05, 32'h0,         0);
      mr(0, 3'd2, 32'h0,         32'h0000_0005, 0);
      mr(1, 3'd3, 32'h1234_5607, 32'h0,         0);
      mr(0, 3'd3, 32'h0,         32'h0000_0007, 0);
      mr(1, 3'd0, 32'hABCD_1234, 32'h0002_000B, 0);
      mr(0, 3'd0, 32'h0,         32'h00CD_0034, 0);
      mr(1, 3'd1, 32'hFFFF_FFFD, 32'h0,         0);
      mr(0, 3'd1, 32'h0,         32'h0000_0001, 1);
      mr(1, 3'd5, 32'hFFFF_FFFF, 32'h0,         1);
      mr(0, 3'd5, 32'h0,         32'h0,         1);
      mr(1, 3'd6, 32'hFFFF_FFFF, 32'h0,         1);
      mr(0, 3'd6, 32'h0,         32'h0,         1);

      foreach (tv[i]) begin
         if (tv[i].rst) do_reset();
         while (cyc < tv[i].cyc) tick();
         slow_access_req = tv[i].req;
         chk($sformatf("tbl%0d_cyc%0d", i, tv[i].cyc),
             32'(sample()), 32'(tv[i].exp));
      end

      do_reset();
      foreach (rv[i]) begin
         cfg_if.cfg_wr    = rv[i].wr;
         cfg_if.cfg_addr  = rv[i].addr;
         cfg_if.cfg_wdata = rv[i].wdata;
         #1;
         chk($sformatf("reg%0d_rd", i), cfg_if.cfg_rdata, rv[i].rdata);
         chk($sformatf("reg%0d_rcpu", i), 32'(reset_cpu), 32'(rv[i].rcpu));
         tick();
      end
      cfg_if.cfg_wr = 1'b0;

      // shrink base_m1 while bc = 9
      do_reset();
      while (cyc < 9) tick();
      cfg_if.cfg_wr    = 1'b1;
      cfg_if.cfg_addr  = 3'd0;
      cfg_if.cfg_wdata = 32'h0000_0003;
      #1;
      chk("t2_old_rd", cfg_if.cfg_rdata, 32'h0002_000B);
      tick();
      cfg_if.cfg_wr = 1'b0;
      #1;
      chk("t2_new_rd", cfg_if.cfg_rdata, 32'h0000_0003);
      bits = '0;
      for (int i = 0; i < 9; i++) begin
         bits[i] = base_rise_enable;
         tick();
      end
      chk("t2_base_ticks", 32'(bits), 32'h0000_0111);

      // hold in phi1 on high level, stretch on lowest channel only
      do_reset();
      cfg_wr(3'd3, 32'h0000_0002);
      while (cyc < 12) tick();
      slow_access_req = 2'b11;
      bad = 0;
      repeat (15) begin
         if (phi !== 2'b01 || enable_cpu !== 1'b0) bad++;
         tick();
      end
      chk("t4_held", bad, 0);
      chk("t4_stretch_on", {phi, stretching}, 3'b101);
      bad = 0;
      repeat (20) begin
         if (phi !== 2'b10 || enable_cpu !== 1'b0 || stretching !== 1'b1)
            bad++;
         tick();
      end
      chk("t4_stretch_hold", bad, 0);
      chk("t4_end", {enable_cpu, slow_fall}, 3'b101);
      tick();
      slow_access_req = 2'b00;
      chk("t4_after", {phi, stretching}, 3'b010);

      // cpu_disable freezes phase while slow channels keep running
      do_reset();
      tick();
      cfg_wr(3'd1, 32'h0000_0002);
      bad   = 0;
      rises = 0;
      repeat (100) begin
         if (phi !== 2'b01 || enable_cpu !== 1'b0) bad++;
         if (slow_rise[0]) rises++;
         tick();
      end
      chk("t5_frozen", bad, 0);
      chk("t5_rises", rises, 4);
      cfg_wr(3'd1, 32'h0000_0000);
      chk("t5_c103", {phi, enable_cpu}, 3'b010);
      tick();
      chk("t5_c104", {phi, enable_cpu}, 3'b010);
      tick();
      chk("t5_c105", {phi, enable_cpu}, 3'b100);
      tick();
      tick();
      chk("t5_c107", {phi, enable_cpu}, 3'b101);

      // reset in the middle of a stretch
      do_reset();
      slow_access_req = 2'b01;
      while (cyc < 10) tick();
      chk("t6_pre", {phi, stretching}, 3'b101);
      cfg_if.cfg_addr = 3'd7;
`ifdef CLOCKGEN_STRETCH_COUNT_EN
      #1;
      chk("t6_cnt", cfg_if.cfg_rdata, 32'd7);
`endif
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      cyc   = 0;
      chk("t6_rst", {phi, stretching, enable_cpu, base_rise_enable, base_high},
          6'b010000);
      chk("t6_cnt0", cfg_if.cfg_rdata, 32'd0);
      bits = '0;
      for (int i = 0; i < 12; i++) begin
         bits[i] = base_rise_enable;
         tick();
      end
      chk("t6_bc_zero", 32'(bits), 32'h0000_0800);
      slow_access_req = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
